tb_result_collector: RTL

//  Downstream consumer of per-testbench done/error pairs from the core amalgam bench set.

---
 rtl/tb_result_collector_if.sv | 32 +++
 rtl/tb_result_collector.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tb_result_collector_if.sv
// Bundle of the bench-set status inputs and the collector's verdict outputs.
// The bench side drives the master modport; the collector uses the slave modport.
interface tb_result_collector_if #(
    parameter int NUM_BENCH = 8,
    parameter int TIMEOUT_W = 24,
    parameter int IDX_W     = 3
);
    logic                 start;
    logic [NUM_BENCH-1:0] bench_done;
    logic [NUM_BENCH-1:0] bench_error;
    logic [NUM_BENCH-1:0] bench_mask;

    logic                 done;
    logic                 error;
    logic                 timeout;
    logic                 first_fail_valid;
    logic [IDX_W-1:0]     first_fail_idx;
    logic [NUM_BENCH-1:0] done_latched;
    logic [TIMEOUT_W-1:0] elapsed;

    modport master (
        output start, bench_done, bench_error, bench_mask,
        input  done, error, timeout, first_fail_valid, first_fail_idx,
               done_latched, elapsed
    );

    modport slave (
        input  start, bench_done, bench_error, bench_mask,
        output done, error, timeout, first_fail_valid, first_fail_idx,
               done_latched, elapsed
    );
endinterface

// File: rtl/tb_result_collector.sv
// Collects per-bench done/error pairs, runs a timeout watchdog and holds a
// single pass/fail verdict plus the index of the first failing bench.
module tb_result_collector #(
    parameter int NUM_BENCH      = 8,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int IDX_W          = 3
) (
    input logic                  clk,
    input logic                  reset,
    tb_result_collector_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [NUM_BENCH-1:0] mask_q;
    logic [NUM_BENCH-1:0] done_latched_q;
    logic                 err_l_q;
    logic                 timeout_q;
    logic                 ff_valid_q;
    logic [IDX_W-1:0]     ff_idx_q;
    logic [TIMEOUT_W-1:0] elapsed_q;

    logic [NUM_BENCH-1:0] err_vec;
    logic                 all_done;
    logic                 watchdog_hit;
    logic                 launch;
    logic                 set_timeout;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_BENCH-1:0] v);
        logic [IDX_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_BENCH; i++) begin
            if (v[i] && !found) begin
                r     = IDX_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Completion looks only at registered latches, so a done sampled on
    // edge k produces the verdict on edge k+1.
    always_comb begin
        err_vec      = bus.bench_error & mask_q;
        all_done     = &(done_latched_q | ~mask_q);
        watchdog_hit = (elapsed_q == TIMEOUT_W'(TIMEOUT_CYCLES));
        launch       = 1'b0;
        set_timeout  = 1'b0;
        state_d      = state_q;
        case (state_q)
            IDLE, PASS, FAIL: begin
                if (bus.start) begin
                    state_d = RUN;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                if (all_done) begin
                    state_d = err_l_q ? FAIL : PASS;
                end else if (watchdog_hit) begin
                    state_d     = FAIL;
                    set_timeout = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q         <= '0;
            done_latched_q <= '0;
            err_l_q        <= 1'b0;
            timeout_q      <= 1'b0;
            ff_valid_q     <= 1'b0;
            ff_idx_q       <= '0;
            elapsed_q      <= '0;
        end else if (launch) begin
            mask_q         <= bus.bench_mask;
            done_latched_q <= '0;
            err_l_q        <= 1'b0;
            timeout_q      <= 1'b0;
            ff_valid_q     <= 1'b0;
            ff_idx_q       <= '0;
            elapsed_q      <= '0;
        end else if (state_q == RUN) begin
            done_latched_q <= done_latched_q | (bus.bench_done & mask_q);
            if (|err_vec) begin
                err_l_q <= 1'b1;
            end
            if (elapsed_q != '1) begin
                elapsed_q <= elapsed_q + 1'b1;
            end
            if ((|err_vec) && !ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_idx_q   <= lowest_idx(err_vec);
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.done             = (state_q == PASS) || (state_q == FAIL);
    assign bus.error            = (state_q == FAIL);
    assign bus.timeout          = timeout_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_idx   = ff_idx_q;
    assign bus.done_latched     = done_latched_q;
    assign bus.elapsed          = elapsed_q;
endmodule
